// File: rtl/acl_pkg.sv
// Shared definitions for the accelerometer SPI responder: register map,
// device ID, configuration reset values, FSM state encoding and the axis
// byte encoder used by the read mux.
package acl_pkg;

  // Register map
  localparam logic [5:0] AddrDevid      = 6'h00;
  localparam logic [5:0] AddrBwRate     = 6'h2C;
  localparam logic [5:0] AddrPowerCtl   = 6'h2D;
  localparam logic [5:0] AddrDataFormat = 6'h31;
  localparam logic [5:0] AddrDataX0     = 6'h32;
  localparam logic [5:0] AddrDataX1     = 6'h33;
  localparam logic [5:0] AddrDataY0     = 6'h34;
  localparam logic [5:0] AddrDataY1     = 6'h35;
  localparam logic [5:0] AddrDataZ0     = 6'h36;
  localparam logic [5:0] AddrDataZ1     = 6'h37;

  localparam logic [7:0] DevId         = 8'hE5;
  localparam logic [7:0] PowerCtlRst   = 8'h00;
  localparam logic [7:0] BwRateRst     = 8'h0A;
  localparam logic [7:0] DataFormatRst = 8'h00;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } acl_state_e;

  // hi=0: low byte v[7:0]; hi=1: sign-extended top two bits.
  function automatic logic [7:0] axis_byte(input logic [9:0] v, input logic hi);
    return hi ? {{6{v[9]}}, v[9:8]} : v[7:0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a third history flop for edge detection.
// Ports:
//   clk, rst  - system clock, async active-high reset
//   din       - asynchronous input
//   dout      - synchronized level
//   rise/fall - one-cycle pulses on synchronized rising/falling edges
// ResetVal sets the idle level so reset never fabricates an edge.
module spi_sync_edge #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= ResetVal;
      s2_q <= ResetVal;
      s3_q <= ResetVal;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign dout = s2_q;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/acl_spi_responder.sv
// SPI mode-3 slave exposing a small accelerometer register file.
// Ports:
//   clk, rst                  - system clock, async active-high reset
//   sclk, ss, mosi, miso      - SPI bus (ss active-low, MSB first)
//   x/y/z_axis_in, sample_valid - 10-bit axis samples and load strobe
//   power_ctl, bw_rate, data_format - configuration registers
//   measure                   - power_ctl[3], gates axis sampling
//   wr_strobe, wr_addr        - commit pulse and address of last write
//   frame_done                - pulse when ss rises to end a frame
module acl_spi_responder
  import acl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] x_axis_in,
  input  logic [9:0] y_axis_in,
  input  logic [9:0] z_axis_in,
  input  logic       sample_valid,
  output logic [7:0] power_ctl,
  output logic [7:0] bw_rate,
  output logic [7:0] data_format,
  output logic       measure,
  output logic       wr_strobe,
  output logic [5:0] wr_addr,
  output logic       frame_done
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.ResetVal(1'b1)) u_sync_sclk (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .dout (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.ResetVal(1'b1)) u_sync_ss (
    .clk  (clk),
    .rst  (rst),
    .din  (ss),
    .dout (ss_s),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  // Same latency as sclk, so mosi stays aligned with the detected edge.
  spi_sync_edge #(.ResetVal(1'b0)) u_sync_mosi (
    .clk  (clk),
    .rst  (rst),
    .din  (mosi),
    .dout (mosi_s),
    .rise (mosi_rise_unused),
    .fall (mosi_fall_unused)
  );

  acl_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;
  logic       rw_q, rw_d, mb_q, mb_d;
  logic [5:0] addr_q, addr_d;
  logic       miso_q, miso_d;
  logic [7:0] power_ctl_q, power_ctl_d;
  logic [7:0] bw_rate_q, bw_rate_d;
  logic [7:0] data_format_q, data_format_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [5:0] wr_addr_q, wr_addr_d;
  logic       frame_done_q, frame_done_d;
  logic [9:0] x_q, y_q, z_q;
  logic [9:0] x_snap_q, y_snap_q, z_snap_q;
  logic [7:0] rd_data;
  logic [7:0] byte_in;
  logic       sclk_unused;

  assign sclk_unused = sclk_s;

  // Live axis registers follow the sensor; snapshot freezes them per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      x_snap_q <= '0;
      y_snap_q <= '0;
      z_snap_q <= '0;
    end else begin
      if (sample_valid && power_ctl_q[3]) begin
        x_q <= x_axis_in;
        y_q <= y_axis_in;
        z_q <= z_axis_in;
      end
      if (ss_fall) begin
        x_snap_q <= x_q;
        y_snap_q <= y_q;
        z_snap_q <= z_q;
      end
    end
  end

  always_comb begin
    case (addr_q)
      AddrDevid:      rd_data = DevId;
      AddrBwRate:     rd_data = bw_rate_q;
      AddrPowerCtl:   rd_data = power_ctl_q;
      AddrDataFormat: rd_data = data_format_q;
      AddrDataX0:     rd_data = axis_byte(x_snap_q, 1'b0);
      AddrDataX1:     rd_data = axis_byte(x_snap_q, 1'b1);
      AddrDataY0:     rd_data = axis_byte(y_snap_q, 1'b0);
      AddrDataY1:     rd_data = axis_byte(y_snap_q, 1'b1);
      AddrDataZ0:     rd_data = axis_byte(z_snap_q, 1'b0);
      AddrDataZ1:     rd_data = axis_byte(z_snap_q, 1'b1);
      default:        rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_d          = rx_q;
    rw_d          = rw_q;
    mb_d          = mb_q;
    addr_d        = addr_q;
    miso_d        = miso_q;
    power_ctl_d   = power_ctl_q;
    bw_rate_d     = bw_rate_q;
    data_format_d = data_format_q;
    wr_strobe_d   = 1'b0;
    wr_addr_d     = wr_addr_q;
    frame_done_d  = 1'b0;
    byte_in       = {rx_q, mosi_s};

    if (ss_s) begin
      // Deselect aborts any partial byte without committing it.
      state_d      = StIdle;
      bit_cnt_d    = 3'd0;
      miso_d       = 1'b0;
      frame_done_d = ss_rise && (state_q != StIdle);
    end else if (ss_fall) begin
      state_d   = StAddr;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
    end else begin
      if (sclk_rise && (state_q != StIdle)) begin
        rx_d      = byte_in[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (state_q == StAddr) begin
            rw_d    = byte_in[7];
            mb_d    = byte_in[6];
            addr_d  = byte_in[5:0];
            state_d = StData;
          end else begin
            if (!rw_q) begin
              unique case (addr_q)
                AddrBwRate:     bw_rate_d     = byte_in;
                AddrPowerCtl:   power_ctl_d   = byte_in;
                AddrDataFormat: data_format_d = byte_in;
                default: ;
              endcase
              if (addr_q inside {AddrBwRate, AddrPowerCtl, AddrDataFormat}) begin
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q;
              end
            end
            if (mb_q) addr_d = addr_q + 6'd1;
          end
        end
      end
      // Mode 3: master samples on rising, so present the next bit on falling.
      // Address was already advanced, so bit_cnt==0 starts the next byte.
      if (sclk_fall && (state_q == StData)) begin
        miso_d = rd_data[3'd7 - bit_cnt_q];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      bit_cnt_q     <= 3'd0;
      rx_q          <= '0;
      rw_q          <= 1'b0;
      mb_q          <= 1'b0;
      addr_q        <= '0;
      miso_q        <= 1'b0;
      power_ctl_q   <= PowerCtlRst;
      bw_rate_q     <= BwRateRst;
      data_format_q <= DataFormatRst;
      wr_strobe_q   <= 1'b0;
      wr_addr_q     <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_q          <= rx_d;
      rw_q          <= rw_d;
      mb_q          <= mb_d;
      addr_q        <= addr_d;
      miso_q        <= miso_d;
      power_ctl_q   <= power_ctl_d;
      bw_rate_q     <= bw_rate_d;
      data_format_q <= data_format_d;
      wr_strobe_q   <= wr_strobe_d;
      wr_addr_q     <= wr_addr_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign miso        = miso_q;
  assign power_ctl   = power_ctl_q;
  assign bw_rate     = bw_rate_q;
  assign data_format = data_format_q;
  assign measure     = power_ctl_q[3];
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_acl_spi_responder.sv
// Directed self-checking bench for acl_spi_responder (SPI mode 3 master model).
module tb_acl_spi_responder;
  import acl_pkg::*;

  localparam time Half = 60ns;  // sclk high/low time, 6 clk periods

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b1;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [9:0] x_axis_in = '0, y_axis_in = '0, z_axis_in = '0;
  logic       sample_valid = 1'b0;
  logic [7:0] power_ctl, bw_rate, data_format;
  logic       measure, wr_strobe, frame_done;
  logic [5:0] wr_addr;

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  logic [5:0] last_wr_addr = '0;

  acl_spi_responder dut (
    .clk          (clk),
    .rst          (rst),
    .sclk         (sclk),
    .ss           (ss),
    .mosi         (mosi),
    .miso         (miso),
    .x_axis_in    (x_axis_in),
    .y_axis_in    (y_axis_in),
    .z_axis_in    (z_axis_in),
    .sample_valid (sample_valid),
    .power_ctl    (power_ctl),
    .bw_rate      (bw_rate),
    .data_format  (data_format),
    .measure      (measure),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .frame_done   (frame_done)
  );

  always #5ns clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt   = strobe_cnt + 1;
      last_wr_addr = wr_addr;
    end
    if (frame_done) done_cnt = done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    ss = 1'b0;
    wait_clks(6);
  endtask

  task automatic frame_end();
    wait_clks(6);
    ss = 1'b1;
    wait_clks(10);
  endtask

  // Shift n bits of tx (MSB first); rx collects miso sampled on rising edges.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      mosi = tx[7-i];
      #Half;
      sclk = 1'b1;
      rx = {rx[6:0], miso};
      #Half;
    end
  endtask

  task automatic pulse_sample(input logic [9:0] x, input logic [9:0] y, input logic [9:0] z);
    @(negedge clk);
    x_axis_in    = x;
    y_axis_in    = y;
    z_axis_in    = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Single-byte read frame: address byte then one dummy byte.
  task automatic read1(input logic [7:0] cmd, output logic [7:0] rx);
    logic [7:0] dummy;
    frame_begin();
    spi_bits(cmd, 8, dummy);
    spi_bits(8'h00, 8, rx);
    frame_end();
  endtask

  task automatic write1(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] dummy;
    frame_begin();
    spi_bits(cmd, 8, dummy);
    spi_bits(data, 8, dummy);
    frame_end();
  endtask

  logic [7:0] rx, addr_rx;
  logic [7:0] mb_rx [6];
  logic [7:0] exp_pre [6] = '{8'h23, 8'h01, 8'hF5, 8'hFF, 8'h00, 8'hFE};
  logic [7:0] exp_new [6] = '{8'hAB, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h01};
  int s0, d0;

  initial begin
    // Reset state
    wait_clks(4);
    check_eq("rst_miso", 32'(miso), 32'h0);
    check_eq("rst_state", 32'(dut.state_q), 32'(StIdle));
    check_eq("rst_power_ctl", 32'(power_ctl), 32'h00);
    check_eq("rst_bw_rate", 32'(bw_rate), 32'h0A);
    check_eq("rst_data_format", 32'(data_format), 32'h00);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'h00);
    rst = 1'b0;
    wait_clks(4);

    // Write 0x2D <- 0x08
    write1(8'h2D, 8'h08);
    check_eq("wr_power_ctl", 32'(power_ctl), 32'h08);
    check_eq("wr_measure", 32'(measure), 32'h1);
    check_eq("wr_strobe_cnt", 32'(strobe_cnt), 32'd1);
    check_eq("wr_addr", 32'(last_wr_addr), 32'h2D);
    check_eq("wr_frame_done", 32'(done_cnt), 32'd1);

    // DEVID read; miso must stay 0 during the address byte
    frame_begin();
    spi_bits(8'h80, 8, addr_rx);
    spi_bits(8'h00, 8, rx);
    frame_end();
    check_eq("addr_phase_miso", 32'(addr_rx), 32'h00);
    check_eq("devid", 32'(rx), 32'hE5);

    // Axis encoding
    pulse_sample(10'h123, 10'h3F5, 10'h200);
    wait_clks(4);
    read1(8'hB4, rx);
    check_eq("y0", 32'(rx), 32'hF5);
    read1(8'hB5, rx);
    check_eq("y1", 32'(rx), 32'hFF);

    // Multibyte read with a mid-frame sample update
    frame_begin();
    spi_bits(8'hF2, 8, addr_rx);
    for (int i = 0; i < 6; i++) begin
      spi_bits(8'h00, 8, mb_rx[i]);
      if (i == 1) pulse_sample(10'h0AB, 10'h001, 10'h1FF);
    end
    frame_end();
    for (int i = 0; i < 6; i++) check_eq($sformatf("mb_snap%0d", i), 32'(mb_rx[i]), 32'(exp_pre[i]));
    frame_begin();
    spi_bits(8'hF2, 8, addr_rx);
    for (int i = 0; i < 6; i++) spi_bits(8'h00, 8, mb_rx[i]);
    frame_end();
    for (int i = 0; i < 6; i++) check_eq($sformatf("mb_new%0d", i), 32'(mb_rx[i]), 32'(exp_new[i]));

    // Multibyte write 0x2C,0x2D via MB
    s0 = strobe_cnt;
    frame_begin();
    spi_bits(8'h6C, 8, rx);
    spi_bits(8'h0F, 8, rx);
    spi_bits(8'h08, 8, rx);
    frame_end();
    check_eq("mbw_bw_rate", 32'(bw_rate), 32'h0F);
    check_eq("mbw_power_ctl", 32'(power_ctl), 32'h08);
    check_eq("mbw_strobes", 32'(strobe_cnt - s0), 32'd2);
    check_eq("mbw_last_addr", 32'(last_wr_addr), 32'h2D);

    // Partial write to 0x31 is discarded
    s0 = strobe_cnt;
    d0 = done_cnt;
    frame_begin();
    spi_bits(8'h31, 8, rx);
    spi_bits(8'h0B, 4, rx);
    frame_end();
    check_eq("part_data_format", 32'(data_format), 32'h00);
    check_eq("part_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check_eq("part_frame_done", 32'(done_cnt - d0), 32'd1);

    // Write to read-only address 0x00 is ignored
    s0 = strobe_cnt;
    write1(8'h00, 8'h55);
    check_eq("ro_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    read1(8'h80, rx);
    check_eq("ro_devid", 32'(rx), 32'hE5);

    // Reset during the DATA phase of an X0 read (0xAB, so miso is high)
    frame_begin();
    spi_bits(8'hB2, 8, rx);
    spi_bits(8'h00, 3, rx);
    check_eq("pre_rst_miso", 32'(miso), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1ns;
    check_eq("midrst_miso", 32'(miso), 32'h0);
    check_eq("midrst_state", 32'(dut.state_q), 32'(StIdle));
    check_eq("midrst_power_ctl", 32'(power_ctl), 32'h00);
    check_eq("midrst_bw_rate", 32'(bw_rate), 32'h0A);
    sclk = 1'b1;
    ss = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(4);
    write1(8'h2D, 8'h08);
    read1(8'hAD, rx);
    check_eq("post_rst_power_ctl", 32'(rx), 32'h08);
    read1(8'hB2, rx);
    check_eq("post_rst_x0", 32'(rx), 32'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/acl_spi_responder.md
ACL_SPI_RESPONDER -- requirements
Module: acl_spi_responder

Interface
REQ-001 clk  input  1  system clock, 100 MHz; sole clock of the block.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 sclk  input  1  SPI clock from master; mode 3 (idles high); asynchronous to clk.
REQ-004 ss  input  1  SPI slave select, active-low; asynchronous to clk.
REQ-005 mosi  input  1  SPI serial data from master, MSB first.
REQ-006 miso  output  1  SPI serial data to master, MSB first; registered.
REQ-007 x_axis_in, y_axis_in, z_axis_in  input  10 each  two's-complement axis samples.
REQ-008 sample_valid  input  1  one-cycle pulse; axis inputs valid.
REQ-009 power_ctl, bw_rate, data_format  output  8 each  configuration register contents.
REQ-010 measure  output  1  equals power_ctl[3].
REQ-011 wr_strobe  output  1  one-cycle pulse when a configuration byte is committed.
REQ-012 wr_addr  output  6  address of the last committed write.
REQ-013 frame_done  output  1  one-cycle pulse on ss rising edge ending a frame.

Function
REQ-014 sclk, ss and mosi SHALL each pass through a 2-flop synchronizer; sclk/ss edges SHALL be detected from the synchronized values.
REQ-015 The block SHALL support sclk high and low times of at least 4 clk periods each.
REQ-016 The FSM SHALL have the states IDLE, ADDR and DATA; ss falling -> ADDR with bit_cnt=0; ss high in any state -> IDLE.
REQ-017 The block SHALL shift mosi on each synchronized sclk rising edge; bit_cnt (3 bits) SHALL wrap 7->0 at each byte boundary.
REQ-018 The first byte SHALL decode as bit7=R/W (1=read), bit6=MB, bits[5:0]=address; after the 8th rising edge the FSM SHALL go ADDR->DATA.
REQ-019 Reads: on each synchronized sclk falling edge in DATA, miso SHALL drive the next bit of the byte at the current address, bit7 first; miso SHALL update within 3 clk cycles of the falling edge at the pin.
REQ-020 Writes: the byte received in DATA SHALL be committed on its 8th rising edge only if the address is 0x2C, 0x2D or 0x31; wr_strobe SHALL pulse in that same cycle.
REQ-021 Writes to any other address SHALL be ignored, with no wr_strobe.
REQ-022 After each data byte, the address SHALL increment when MB=1, wrapping 0x3F->0x00; it SHALL stay unchanged when MB=0.
REQ-023 Read map: 0x00 = 0xE5 (DEVID); 0x2C/0x2D/0x31 = configuration registers; 0x32-0x37 = X0,X1,Y0,Y1,Z0,Z1; all other addresses = 0x00.
REQ-024 Axis byte encoding: axis0 = v[7:0]; axis1 = {6{v[9]}, v[9:8]}.
REQ-025 Axis data registers SHALL load on sample_valid only when measure=1.
REQ-026 A frame SHALL read from a snapshot of the axis registers taken on ss falling; a sample_valid during a frame SHALL update the live registers only.
REQ-027 ss rising mid-byte SHALL discard the partial byte (no commit) and pulse frame_done.
REQ-028 miso SHALL be 0 in IDLE and in ADDR.

Reset
REQ-029 On rst: FSM=IDLE, bit_cnt=0, miso=0, power_ctl=0x00, bw_rate=0x0A, data_format=0x00, axis and snapshot registers=0, wr_strobe=0, wr_addr=0, frame_done=0; the synchronizers SHALL reset to the idle values sclk=1, ss=1.
REQ-030 rst asserted mid-frame SHALL abort the frame; the first frame after rst is released SHALL begin at the next ss falling edge.

Structure
REQ-031 Shared package acl_pkg SHALL hold the register addresses, DEVID=0xE5, the configuration reset values, and the state encoding.
REQ-032 A sub-module spi_sync_edge (2-flop synchronizer plus rise/fall pulse outputs) SHALL be instantiated for sclk and ss; mosi SHALL use its synchronized output only.

Verification
REQ-033 Write frame 0x2D,0x08 -> power_ctl=0x08, measure=1, one wr_strobe with wr_addr=0x2D, then frame_done.
REQ-034 Read frame 0x80 + 1 dummy byte -> master receives 0xE5.
REQ-035 measure=1, y_axis_in=0x3F5 with sample_valid; single reads 0xB4 then 0xB5 -> 0xF5, then 0xFF.
REQ-036 Multibyte read 0xF2 + 6 bytes, with sample_valid and new values pulsed after the 2nd byte -> all six bytes come from the pre-frame snapshot; the next frame returns the new values.
REQ-037 Write 0x31 with ss raised after 4 data bits -> data_format unchanged, no wr_strobe, frame_done pulses; write 0x00,0x55 -> ignored, DEVID still reads 0xE5.
REQ-038 rst pulsed during the DATA phase of a read -> miso=0 and FSM=IDLE immediately, configuration at reset values; the next full frame operates normally.
